// File: rtl/cr_div_p.sv
// rtl/cr_div_p.sv - cached-reciprocal divider
// Caches floor(2^WID/|b|) per slot; a repeated divisor costs one multiply plus one correction step.
module cr_div_p #(
  parameter int WID  = 32,
  parameter int IDXW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [WID-1:0] addr,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic           flush,
  output logic           busy,
  output logic           done,
  output logic [WID-1:0] q,
  output logic [WID-1:0] r,
  output logic           dz,
  output logic           hit
);
  localparam int             NENT    = 1 << IDXW;
  localparam int             CW      = $clog2(WID + 1);
  localparam logic [CW-1:0]  CNT_TOP = CW'(WID);
  localparam logic [WID-1:0] ONES    = '1;
  localparam logic [WID-1:0] ONE     = WID'(1);
  localparam logic [WID-1:0] MIN_V   = {1'b1, {(WID-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RECIP, S_MUL, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, dz_q, dz_d, hit_q, hit_d;
  logic [WID-1:0]  q_q, q_d, r_q, r_d;
  logic [WID-1:0]  a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WID-1:0]  recip_q, recip_d, quo_q, quo_d, rem_q, rem_d, p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NENT-1:0] valid_q, valid_d;

  logic [WID-1:0]  tag_ram   [NENT];
  logic [WID-1:0]  recip_ram [NENT];

  logic [IDXW-1:0]  in_idx;
  logic [WID-1:0]   a_mag_in, b_mag_in;
  logic [WID:0]     rem_sh, rem_sub;
  logic             rbit;
  logic [2*WID-1:0] prod;
  logic [WID:0]     bp, rr, rr_fix;
  logic [WID-1:0]   p_fix;
  logic             wr_en;
  logic             unused_bits;

  assign in_idx   = addr[IDXW+1:2];
  assign a_mag_in = (sgn && a[WID-1]) ? -a : a;
  assign b_mag_in = (sgn && b[WID-1]) ? -b : b;

  // Restoring step: the dividend 2^WID contributes a single 1 on the first step only.
  assign rem_sh  = {rem_q, (cnt_q == CNT_TOP)};
  assign rem_sub = rem_sh - {1'b0, b_mag_q};
  assign rbit    = (rem_sh >= {1'b0, b_mag_q});

  assign prod = {{WID{1'b0}}, recip_q} * {{WID{1'b0}}, a_mag_q};
  assign bp   = {1'b0, b_mag_q} * {1'b0, p_q};
  assign rr   = {1'b0, a_mag_q} - bp;

  assign unused_bits = ^{addr[WID-1:IDXW+2], addr[1:0], prod[WID-1:0], rem_sub[WID], rr_fix[WID]};

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hit_d   = hit_q;
    q_d     = q_q;
    r_d     = r_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    idx_d   = idx_q;
    recip_d = recip_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;

    // The estimate never overshoots and is at most one short.
    p_fix  = p_q;
    rr_fix = rr;
    if (rr >= {1'b0, b_mag_q}) begin
      p_fix  = p_q + ONE;
      rr_fix = rr - {1'b0, b_mag_q};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          a_mag_d = a_mag_in;
          b_mag_d = b_mag_in;
          neg_q_d = sgn & (a[WID-1] ^ b[WID-1]);
          neg_r_d = sgn & a[WID-1];
          idx_d   = in_idx;
          dz_d    = 1'b0;
          hit_d   = 1'b0;
          if (b == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            q_d     = ONES;
            r_d     = a;
            dz_d    = 1'b1;
          end else if (sgn && a == MIN_V && b == ONES) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            q_d     = MIN_V;
            r_d     = '0;
          end else if (b_mag_in == ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            q_d     = (sgn && b == ONES) ? -a : a;
            r_d     = '0;
          end else if (valid_q[in_idx] && tag_ram[in_idx] == b_mag_in) begin
            state_d = S_MUL;
            hit_d   = 1'b1;
            recip_d = recip_ram[in_idx];
          end else begin
            state_d = S_RECIP;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CNT_TOP;
          end
        end
      end
      S_RECIP: begin
        rem_d = rbit ? rem_sub[WID-1:0] : rem_sh[WID-1:0];
        quo_d = {quo_q[WID-2:0], rbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          recip_d = quo_d;
          wr_en   = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        p_d     = prod[2*WID-1:WID];
        state_d = S_FIX;
      end
      S_FIX: begin
        q_d     = neg_q_q ? -p_fix : p_fix;
        r_d     = neg_r_q ? -rr_fix[WID-1:0] : rr_fix[WID-1:0];
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    valid_d = valid_q;
    if (wr_en) valid_d[idx_q] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hit_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      idx_q   <= '0;
      recip_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hit_q   <= hit_d;
      q_q     <= q_d;
      r_q     <= r_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      idx_q   <= idx_d;
      recip_q <= recip_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_ram[idx_q]   <= b_mag_q;
      recip_ram[idx_q] <= quo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;
  assign hit  = hit_q;

endmodule
